// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver peripheral: register offsets,
// STATUS bit positions, receive FSM encoding and small helper functions.
package uart_rx_pkg;

    // Register offsets within the peripheral's addr[3:0] window
    localparam logic [3:0] REG_RXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h2;
    localparam logic [3:0] REG_DIV    = 4'h4;

    // STATUS register bit positions
    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_FRAME_ERR  = 3;
    localparam int STAT_PARITY_ERR = 4;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_W    = 5;

    // Ticks per bit period and the sample points derived from it
    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] SAMPLE_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

    // Even parity: the bit that makes the total number of ones even
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Reset baud divisor, floored, clamped to 1..65535
    function automatic logic [15:0] reset_divisor(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        if (d < 1) begin
            d = 1;
        end else if (d > 65535) begin
            d = 65535;
        end
        return 16'(d);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters. A push and a pop in the same cycle
// both succeed, even when the FIFO is full, leaving the count unchanged.
module uart_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int          DEPTH      = 2 ** AW;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO   = {(AW + 1){1'b0}};
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accept a push when there is room or when a pop frees a slot this cycle
    always_comb begin
        pop_ok_s  = pop & (count_r != CNT_ZERO);
        push_ok_s = push & ((count_r != FULL_COUNT) | pop_ok_s);
    end

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == CNT_ZERO);
    assign count = count_r;

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART receiver on the J1 I/O bus: 16x oversampling, 8N1 deframing and a
// byte FIFO drained through the RXDATA register.
// Optional build macro PERIPHERAL_UART_RX_PARITY_EN adds one even-parity bit
// between the data bits and the stop bit.
module peripheral_uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam logic [15:0] DIV_RESET = reset_divisor(CLK_FREQ, BAUD);

    // Line synchronizer and edge detect
    logic sync_meta_r;
    logic sync_line_r;
    logic line_prev_r;
    logic fall_s;

    // Baud tick generation
    logic [15:0] div_r;
    logic [15:0] tick_cnt_r;
    logic        tick_s;

    // Receive FSM
    rx_state_t   state_r;
    logic [3:0]  sample_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        push_r;
    logic        frame_set_r;
    logic        parity_set_r;
    logic        parity_bad_r;

    // FIFO and bus side
    logic [7:0]         fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [FIFO_AW:0]   fifo_count_s;
    logic               rd_data_sel_s;
    logic               rd_data_sel_d_r;
    logic               pop_s;
    logic               wr_status_s;
    logic               wr_div_s;
    logic               overrun_set_s;
    logic               overrun_r;
    logic               frame_err_r;
    logic               parity_err_r;
    logic               rx_irq_r;
    logic [15:0]        status_s;

    // Bus decode, pop edge detection and tick/edge strobes
    always_comb begin
        rd_data_sel_s = cs & rd & (addr == REG_RXDATA);
        pop_s         = rd_data_sel_s & ~rd_data_sel_d_r & ~fifo_empty_s;
        wr_status_s   = cs & wr & (addr == REG_STATUS);
        wr_div_s      = cs & wr & (addr == REG_DIV);
        overrun_set_s = push_r & fifo_full_s & ~pop_s;
        tick_s        = (tick_cnt_r == (div_r - 16'd1));
        fall_s        = line_prev_r & ~sync_line_r;
    end

    // Two-flop synchronizer (idles high) plus previous-value flop for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            sync_line_r <= 1'b1;
            line_prev_r <= 1'b1;
        end else begin
            sync_meta_r <= uart_rx;
            sync_line_r <= sync_meta_r;
            line_prev_r <= sync_line_r;
        end
    end

    // Divisor register and oversample tick counter; a DIV write restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r      <= DIV_RESET;
            tick_cnt_r <= 16'd0;
        end else if (wr_div_s) begin
            div_r      <= (d_in == 16'h0000) ? 16'h0001 : d_in;
            tick_cnt_r <= 16'd0;
        end else if (tick_s) begin
            tick_cnt_r <= 16'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

    // Receive FSM: mid-bit sampling of start, data, optional parity and stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            sample_cnt_r <= 4'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            push_r       <= 1'b0;
            frame_set_r  <= 1'b0;
            parity_set_r <= 1'b0;
            parity_bad_r <= 1'b0;
        end else begin
            push_r       <= 1'b0;
            frame_set_r  <= 1'b0;
            parity_set_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // A falling edge needs the line high first, so after a
                    // frame error we naturally wait for the line to recover.
                    if (fall_s) begin
                        state_r      <= S_START;
                        sample_cnt_r <= 4'd0;
                    end
                end
                S_START: begin
                    if (tick_s) begin
                        if (sample_cnt_r == SAMPLE_MID) begin
                            sample_cnt_r <= 4'd0;
                            if (sync_line_r) begin
                                state_r <= S_IDLE;
                            end else begin
                                state_r      <= S_DATA;
                                bit_cnt_r    <= 3'd0;
                                parity_bad_r <= 1'b0;
                            end
                        end else begin
                            sample_cnt_r <= sample_cnt_r + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        if (sample_cnt_r == SAMPLE_LAST) begin
                            sample_cnt_r <= 4'd0;
                            shift_r      <= {sync_line_r, shift_r[7:1]};
                            if (bit_cnt_r == 3'd7) begin
`ifdef PERIPHERAL_UART_RX_PARITY_EN
                                state_r <= S_PARITY;
`else
                                state_r <= S_STOP;
`endif
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            sample_cnt_r <= sample_cnt_r + 4'd1;
                        end
                    end
                end
`ifdef PERIPHERAL_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_s) begin
                        if (sample_cnt_r == SAMPLE_LAST) begin
                            sample_cnt_r <= 4'd0;
                            state_r      <= S_STOP;
                            if (sync_line_r != even_parity(shift_r)) begin
                                parity_bad_r <= 1'b1;
                                parity_set_r <= 1'b1;
                            end
                        end else begin
                            sample_cnt_r <= sample_cnt_r + 4'd1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick_s) begin
                        if (sample_cnt_r == SAMPLE_LAST) begin
                            sample_cnt_r <= 4'd0;
                            state_r      <= S_IDLE;
                            if (sync_line_r) begin
                                push_r <= ~parity_bad_r;
                            end else begin
                                frame_set_r <= 1'b1;
                            end
                        end else begin
                            sample_cnt_r <= sample_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    sample_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .pop   (pop_s),
        .din   (shift_r),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Sticky error flags: a new error in the same cycle as a W1C keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            overrun_r    <= overrun_set_s | (overrun_r & ~(wr_status_s & d_in[STAT_OVERRUN]));
            frame_err_r  <= frame_set_r | (frame_err_r & ~(wr_status_s & d_in[STAT_FRAME_ERR]));
            parity_err_r <= parity_set_r | (parity_err_r & ~(wr_status_s & d_in[STAT_PARITY_ERR]));
        end
    end

    // Read-strobe history for single pop per access, and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_sel_d_r <= 1'b0;
            rx_irq_r        <= 1'b0;
        end else begin
            rd_data_sel_d_r <= rd_data_sel_s;
            rx_irq_r        <= ~fifo_empty_s;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                                   = 16'h0000;
        status_s[STAT_NOT_EMPTY]                   = ~fifo_empty_s;
        status_s[STAT_FULL]                        = fifo_full_s;
        status_s[STAT_OVERRUN]                     = overrun_r;
        status_s[STAT_FRAME_ERR]                   = frame_err_r;
        status_s[STAT_PARITY_ERR]                  = parity_err_r;
        status_s[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(fifo_count_s);
    end

    // Read data mux; zero whenever this peripheral is not being read
    always_comb begin
        d_out = 16'h0000;
        if (cs & rd) begin
            case (addr)
                REG_RXDATA: begin
                    if (fifo_empty_s) begin
                        d_out = 16'h0000;
                    end else begin
                        d_out = {8'h00, fifo_dout_s};
                    end
                end
                REG_STATUS: d_out = status_s;
                REG_DIV:    d_out = div_r;
                default:    d_out = 16'h0000;
            endcase
        end else begin
            d_out = 16'h0000;
        end
    end

    assign rx_irq = rx_irq_r;

endmodule
